// File: rtl/branch_predict_table.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_table
// Desc     : Table of 2^IDX_W saturating CNT_W-bit direction counters with a
//            registered lookup port, a training port and a saturating
//            mispredict count. Define GSHARE_EN for gshare (history-XOR) indexing.
// Revision : 1.0  initial release
// ============================================================================
module branch_predict_table #(
  parameter int CNT_W  = 2,
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4,
  parameter int MISS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [IDX_W-1:0]  lookup_idx,
  input  logic              update_valid,
  input  logic [IDX_W-1:0]  update_idx,
  input  logic              update_taken,
  input  logic              update_pred,
  output logic              predict,
  output logic              predict_valid,
  output logic [MISS_W-1:0] miss_count
);

  localparam int                c_depth    = 1 << IDX_W;
  localparam logic [CNT_W-1:0]  c_cnt_init = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max  = '1;
  localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
  localparam logic [MISS_W-1:0] c_miss_max = '1;
  localparam logic [MISS_W-1:0] c_miss_one = MISS_W'(1);

  logic [CNT_W-1:0]  r_table [c_depth];
  logic              r_predict;
  logic              r_predict_valid;
  logic [MISS_W-1:0] r_miss_count;

  logic [IDX_W-1:0]  w_lk_eidx;
  logic [IDX_W-1:0]  w_up_eidx;
  logic [CNT_W-1:0]  w_up_cur;
  logic [CNT_W-1:0]  w_up_next;
  logic              w_bypass;
  logic              w_miss;

`ifdef GSHARE_EN
  logic [HIST_W-1:0] r_ghr;
  logic [HIST_W:0]   w_ghr_shift;
  logic [IDX_W-1:0]  w_hist;

  // Both ports hash with the history as it stood before this cycle's shift.
  assign w_hist      = IDX_W'(r_ghr);
  assign w_ghr_shift = {r_ghr, update_taken};
  assign w_lk_eidx   = lookup_idx ^ w_hist;
  assign w_up_eidx   = update_idx ^ w_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (update_valid) begin
      r_ghr <= w_ghr_shift[HIST_W-1:0];
    end
  end
`else
  assign w_lk_eidx = lookup_idx;
  assign w_up_eidx = update_idx;
`endif

  assign w_up_cur = r_table[w_up_eidx];

  always_comb begin
    w_up_next = w_up_cur;
    if (update_taken) begin
      if (w_up_cur != c_cnt_max) w_up_next = w_up_cur + c_cnt_one;
    end else begin
      if (w_up_cur != '0) w_up_next = w_up_cur - c_cnt_one;
    end
  end

  assign w_bypass = update_valid && (w_up_eidx == w_lk_eidx);
  assign w_miss   = update_valid && (update_taken != update_pred);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_depth; i++) r_table[i] <= c_cnt_init;
    end else if (update_valid) begin
      r_table[w_up_eidx] <= w_up_next;
    end
  end

  // A same-cycle update to the looked-up entry forwards its new counter value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_predict       <= 1'b0;
      r_predict_valid <= 1'b0;
    end else begin
      r_predict_valid <= lookup_valid;
      if (lookup_valid) begin
        r_predict <= w_bypass ? w_up_next[CNT_W-1] : r_table[w_lk_eidx][CNT_W-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miss_count <= '0;
    end else if (w_miss && (r_miss_count != c_miss_max)) begin
      r_miss_count <= r_miss_count + c_miss_one;
    end
  end

  assign predict       = r_predict;
  assign predict_valid = r_predict_valid;
  assign miss_count    = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_table
// Desc     : Self-checking bench: vector table plus corner-case sequences,
//            predictions scored through an expected-value queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predict_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [3:0]  lookup_idx;
  logic        update_valid;
  logic [3:0]  update_idx;
  logic        update_taken;
  logic        update_pred;
  logic        predict;
  logic        predict_valid;
  logic [15:0] miss_count;
  logic        sat_predict;
  logic        sat_predict_valid;
  logic [3:0]  sat_miss_count;

  typedef struct {
    logic       lv;
    logic [3:0] li;
    logic       uv;
    logic [3:0] ui;
    logic       ut;
    logic       up;
    logic       ep;
  } vec_t;

  vec_t vecs[$];
  logic exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  branch_predict_table #(.CNT_W(2), .IDX_W(4), .HIST_W(4), .MISS_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .update_valid(update_valid), .update_idx(update_idx),
    .update_taken(update_taken), .update_pred(update_pred),
    .predict(predict), .predict_valid(predict_valid), .miss_count(miss_count)
  );

  // Narrow mispredict counter so saturation is reachable in a few cycles.
  branch_predict_table #(.CNT_W(2), .IDX_W(4), .HIST_W(4), .MISS_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .update_valid(update_valid), .update_idx(update_idx),
    .update_taken(update_taken), .update_pred(update_pred),
    .predict(sat_predict), .predict_valid(sat_predict_valid), .miss_count(sat_miss_count)
  );

  function automatic vec_t mk(input logic lv, input logic [3:0] li, input logic uv,
                              input logic [3:0] ui, input logic ut, input logic up,
                              input logic ep);
    vec_t v;
    v.lv = lv; v.li = li; v.uv = uv; v.ui = ui; v.ut = ut; v.up = up; v.ep = ep;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lookup_valid = 1'b0; lookup_idx = '0;
    update_valid = 1'b0; update_idx = '0;
    update_taken = 1'b0; update_pred = 1'b0;
  endtask

  // Drive one cycle, then score the registered outputs just after the edge.
  task automatic step(input vec_t v, input string nm);
    logic e;
    lookup_valid = v.lv; lookup_idx = v.li;
    update_valid = v.uv; update_idx = v.ui;
    update_taken = v.ut; update_pred = v.up;
    if (v.lv) exp_q.push_back(v.ep);
    @(posedge clk); #1;
    check({nm, ".pv"}, {31'd0, predict_valid}, {31'd0, v.lv});
    if (predict_valid) begin
      if (exp_q.size() == 0) begin
        check({nm, ".unexpected"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({nm, ".pred"}, {31'd0, predict}, {31'd0, e});
      end
    end
    idle_inputs();
  endtask

  task automatic do_reset(input string nm);
    idle_inputs();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check({nm, ".rst_pred"}, {31'd0, predict}, 32'd0);
    check({nm, ".rst_pv"},   {31'd0, predict_valid}, 32'd0);
    check({nm, ".rst_miss"}, {16'd0, miss_count}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: back-to-back lookups of a fresh table, then train entry 5.
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 4'(i), 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)  vecs.push_back(mk(0, 0, 1, 5, 1, 1, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 1));   // 11
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0));   // 10
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0));   // 01
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0));   // 00
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5, 0, 0, 0));   // stays 00
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 5, 1, 1, 0));   // 01
    vecs.push_back(mk(0, 0, 1, 5, 1, 1, 0));   // 10
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));

    do_reset("init");
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Bypass: same-cycle lookup and update of entry 7, then a different entry.
    do_reset("byp");
    step(mk(1, 7, 1, 7, 1, 1, 1), "byp_same");
    do_reset("byp2");
    step(mk(1, 8, 1, 7, 1, 1, 0), "byp_diff");
    step(mk(1, 7, 0, 0, 0, 0, 1), "byp_diff_after");

    // Mispredict count: 5 misses among 7 updates, then saturation of the narrow copy.
    do_reset("miss");
    step(mk(0, 0, 1, 1, 1, 0, 0), "miss0");
    step(mk(0, 0, 1, 2, 0, 1, 0), "miss1");
    step(mk(0, 0, 1, 3, 1, 1, 0), "miss2");
    step(mk(0, 0, 1, 4, 1, 0, 0), "miss3");
    step(mk(0, 0, 1, 5, 0, 0, 0), "miss4");
    step(mk(0, 0, 1, 6, 0, 1, 0), "miss5");
    step(mk(0, 0, 1, 7, 1, 0, 0), "miss6");
    check("miss_five",     {16'd0, miss_count}, 32'd5);
    check("miss_sat_five", {28'd0, sat_miss_count}, 32'd5);
    for (int i = 0; i < 9; i++) step(mk(0, 0, 1, 4'(i), 1, 0, 0), $sformatf("missb%0d", i));
    check("miss_sat_14", {28'd0, sat_miss_count}, 32'd14);
    step(mk(0, 0, 1, 9, 0, 1, 0), "miss_to_max");
    check("miss_sat_15", {28'd0, sat_miss_count}, 32'd15);
    check("miss_main_15", {16'd0, miss_count}, 32'd15);
    step(mk(0, 0, 1, 9, 0, 1, 0), "miss_over");
    check("miss_sat_hold", {28'd0, sat_miss_count}, 32'd15);
    check("miss_main_16",  {16'd0, miss_count}, 32'd16);

    // Asynchronous reset in the middle of a lookup.
    do_reset("mid");
    for (int i = 0; i < 3; i++) step(mk(0, 0, 1, 5, 1, 0, 0), $sformatf("mid_train%0d", i));
    step(mk(1, 5, 0, 0, 0, 0, 1), "mid_pre");
    check("mid_pre_miss", {16'd0, miss_count}, 32'd3);
    lookup_valid = 1'b1; lookup_idx = 4'd5;
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_pred", {31'd0, predict}, 32'd0);
    check("mid_async_pv",   {31'd0, predict_valid}, 32'd0);
    check("mid_async_miss", {16'd0, miss_count}, 32'd0);
    exp_q.delete();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_release_pv", {31'd0, predict_valid}, 32'd0);
    step(mk(1, 5, 0, 0, 0, 0, 0), "mid_post");

    // History-indexing scenario.
    do_reset("gsh");
    step(mk(0, 0, 1, 0, 1, 1, 0), "gsh_u0a");
    step(mk(0, 0, 1, 0, 1, 1, 0), "gsh_u0b");
    for (int i = 0; i < 3; i++) step(mk(0, 0, 1, 4, 1, 1, 0), $sformatf("gsh_u4_%0d", i));
`ifdef GSHARE_EN
    // Third idx-4 update landed on entry 4^1111=11, lifting it to 10.
    step(mk(1, 4, 0, 0, 0, 0, 1), "gsh_lk4");
    step(mk(1, 0, 0, 0, 0, 0, 0), "gsh_lk0");
`else
    step(mk(1, 4, 0, 0, 0, 0, 1), "gsh_lk4");
    step(mk(1, 0, 0, 0, 0, 0, 1), "gsh_lk0");
`endif
    step(mk(0, 0, 0, 0, 0, 0, 0), "gsh_idle");
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
